fetch_unit: RTL and testbench

Instruction fetch and decode front end for the RISC-Y core. It owns the program counter and instruction register, and runs the instruction-memory read handshake, including one indirect-address read when the I bit is set. It drives the `OPCODE`, `I_Flag` and `InstADDR` fields that `Controller` reads. It acts on the `IR_EN`, `PC_EN` and `PC_LOAD` strobes that `Controller` issues.

---
 rtl/risc_pkg.sv | 35 +++
 rtl/program_counter.sv | 38 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC-Y definitions: datapath widths, instruction field positions,
// the fetch FSM state encoding and the opcode set decoded by Controller.
package risc_pkg;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned INSTR_W = 12;

    // Instruction word: [11:8] opcode, [7] indirect bit, [6:0] address
    localparam int unsigned OPC_MSB  = INSTR_W - 1;
    localparam int unsigned OPC_LSB  = ADDR_W + 1;
    localparam int unsigned IBIT_POS = ADDR_W;
    localparam int unsigned ADDR_MSB = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        INDIR = 2'd2
    } fetch_state_t;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_LDA = 4'h6,
        OP_STA = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_HLT = 4'hF
    } opcode_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: branch load beats increment, increment wraps at 2^ADDR_W,
// and the whole register holds while frozen.
module program_counter #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              freeze_i,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (!freeze_i) begin
            if (load_i) begin
                pc_d = load_addr_i;
            end else if (inc_i) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns PC and IR, runs the memory read handshake
// including one indirect address read when the I bit is set.
module fetch_unit #(
    parameter int unsigned ADDR_W  = risc_pkg::ADDR_W,
    parameter int unsigned OPC_W   = risc_pkg::OPC_W,
    parameter int unsigned INSTR_W = risc_pkg::INSTR_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Ena,
    input  logic               IR_EN,
    input  logic               PC_EN,
    input  logic               PC_LOAD,
    input  logic               MEM_ACK,
    input  logic [INSTR_W-1:0] MEM_DATA,
    output logic               MEM_REQ,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [OPC_W-1:0]   OPCODE,
    output logic               I_Flag,
    output logic [ADDR_W-1:0]  InstADDR,
    output logic [ADDR_W-1:0]  PC_ADDR,
    output logic               FETCH_BUSY,
    output logic               IR_VALID
);

    import risc_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic              ibit_q, ibit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0] pc;
    logic              ack;

    // An ack only counts against an outstanding request
    assign ack = MEM_ACK & mem_req_q;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .freeze_i   (Ena),
        .inc_i      (PC_EN),
        .load_i     (PC_LOAD),
        .load_addr_i(addr_q),
        .pc_o       (pc)
    );

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        ibit_d     = ibit_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        ir_valid_d = 1'b0;
        if (!Ena) begin
            unique case (state_q)
                IDLE: begin
                    if (IR_EN) begin
                        state_d    = FETCH;
                        mem_addr_d = pc;
                        mem_req_d  = 1'b1;
                    end
                end
                FETCH: begin
                    if (ack) begin
                        opc_d  = MEM_DATA[OPC_MSB:OPC_LSB];
                        ibit_d = MEM_DATA[IBIT_POS];
                        addr_d = MEM_DATA[ADDR_MSB:0];
                        if (MEM_DATA[IBIT_POS]) begin
                            state_d    = INDIR;
                            mem_addr_d = MEM_DATA[ADDR_MSB:0];
                        end else begin
                            state_d    = IDLE;
                            mem_req_d  = 1'b0;
                            ir_valid_d = 1'b1;
                        end
                    end
                end
                INDIR: begin
                    if (ack) begin
                        addr_d     = MEM_DATA[ADDR_MSB:0];
                        state_d    = IDLE;
                        mem_req_d  = 1'b0;
                        ir_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            opc_q      <= '0;
            ibit_q     <= 1'b0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            ibit_q     <= ibit_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign MEM_REQ    = mem_req_q;
    assign MEM_ADDR   = mem_addr_q;
    assign OPCODE     = opc_q;
    assign I_Flag     = ibit_q;
    assign InstADDR   = addr_q;
    assign PC_ADDR    = pc;
    assign FETCH_BUSY = (state_q != IDLE);
    assign IR_VALID   = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; completed instructions are checked against
// a scoreboard of expected IR contents queued when each fetch is launched.
module tb_fetch_unit;

    typedef struct packed {
        logic [3:0] opc;
        logic       ibit;
        logic [6:0] addr;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, Ena, IR_EN, PC_EN, PC_LOAD, MEM_ACK;
    logic [11:0] MEM_DATA;
    logic        MEM_REQ, I_Flag, FETCH_BUSY, IR_VALID;
    logic [6:0]  MEM_ADDR, InstADDR, PC_ADDR;
    logic [3:0]  OPCODE;

    int   errors = 0;
    int   checks = 0;
    int   vcount = 0;
    exp_t sb[$];

    fetch_unit #(.ADDR_W(7), .OPC_W(4), .INSTR_W(12)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Ena       (Ena),
        .IR_EN     (IR_EN),
        .PC_EN     (PC_EN),
        .PC_LOAD   (PC_LOAD),
        .MEM_ACK   (MEM_ACK),
        .MEM_DATA  (MEM_DATA),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .OPCODE    (OPCODE),
        .I_Flag    (I_Flag),
        .InstADDR  (InstADDR),
        .PC_ADDR   (PC_ADDR),
        .FETCH_BUSY(FETCH_BUSY),
        .IR_VALID  (IR_VALID)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (IR_VALID === 1'b1) vcount++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_valid(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(IR_VALID), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_opc"},  32'(OPCODE),   32'(e.opc));
            chk({tag, "_ibit"}, 32'(I_Flag),   32'(e.ibit));
            chk({tag, "_addr"}, 32'(InstADDR), 32'(e.addr));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(MEM_REQ),    32'd0);
        chk({tag, "_maddr"}, 32'(MEM_ADDR),   32'd0);
        chk({tag, "_opc"},   32'(OPCODE),     32'd0);
        chk({tag, "_ibit"},  32'(I_Flag),     32'd0);
        chk({tag, "_iaddr"}, 32'(InstADDR),   32'd0);
        chk({tag, "_pc"},    32'(PC_ADDR),    32'd0);
        chk({tag, "_busy"},  32'(FETCH_BUSY), 32'd0);
        chk({tag, "_valid"}, 32'(IR_VALID),   32'd0);
    endtask

    initial begin
        RST = 1'b0; Ena = 1'b0; IR_EN = 1'b0; PC_EN = 1'b0; PC_LOAD = 1'b0;
        MEM_ACK = 1'b0; MEM_DATA = '0;
        #3;
        check_reset_outputs("rst");
        #9 RST = 1'b1;

        // PC increments then loads InstADDR (0 after reset)
        PC_EN = 1'b1;
        tick(); chk("pc_inc1", 32'(PC_ADDR), 32'd1);
        tick(); chk("pc_inc2", 32'(PC_ADDR), 32'd2);
        tick(); chk("pc_inc3", 32'(PC_ADDR), 32'd3);
        PC_EN = 1'b0; PC_LOAD = 1'b1;
        tick(); chk("pc_load0", 32'(PC_ADDR), 32'd0);
        PC_LOAD = 1'b0;

        // Direct fetch from PC=5 with two wait cycles
        PC_EN = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        PC_EN = 1'b0;
        chk("pc_5", 32'(PC_ADDR), 32'd5);
        IR_EN = 1'b1;
        sb.push_back('{opc: 4'h1, ibit: 1'b0, addr: 7'h23});
        tick();
        IR_EN = 1'b0;
        chk("d_req0", 32'(MEM_REQ), 32'd1);
        chk("d_maddr", 32'(MEM_ADDR), 32'd5);
        chk("d_busy", 32'(FETCH_BUSY), 32'd1);
        tick(); chk("d_req1", 32'(MEM_REQ), 32'd1);
        tick(); chk("d_req2", 32'(MEM_REQ), 32'd1);
        chk("d_novalid", 32'(IR_VALID), 32'd0);
        MEM_ACK = 1'b1; MEM_DATA = 12'h123;
        tick();
        check_valid("d");
        chk("d_req_off", 32'(MEM_REQ), 32'd0);
        MEM_ACK = 1'b0;
        tick();
        chk("d_pulse", 32'(IR_VALID), 32'd0);
        chk("d_idle", 32'(FETCH_BUSY), 32'd0);

        // Indirect fetch: MEM_ADDR 5 -> 0x20 with no request gap
        IR_EN = 1'b1;
        sb.push_back('{opc: 4'h2, ibit: 1'b1, addr: 7'h45});
        tick();
        IR_EN = 1'b0;
        chk("i_maddr0", 32'(MEM_ADDR), 32'd5);
        MEM_ACK = 1'b1; MEM_DATA = 12'h2A0;
        tick();
        chk("i_req", 32'(MEM_REQ), 32'd1);
        chk("i_maddr1", 32'(MEM_ADDR), 32'h20);
        chk("i_novalid", 32'(IR_VALID), 32'd0);
        chk("i_busy", 32'(FETCH_BUSY), 32'd1);
        MEM_DATA = 12'h045;
        tick();
        check_valid("i");
        chk("i_req_off", 32'(MEM_REQ), 32'd0);
        MEM_ACK = 1'b0;

        // Fetch an instruction with address 0x10 for the branch tests
        IR_EN = 1'b1;
        sb.push_back('{opc: 4'h3, ibit: 1'b0, addr: 7'h10});
        tick();
        IR_EN = 1'b0; MEM_ACK = 1'b1; MEM_DATA = 12'h310;
        tick();
        check_valid("b");
        MEM_ACK = 1'b0;

        // Load beats increment at PC=127; increment alone wraps to 0
        PC_EN = 1'b1;
        for (int i = 0; i < 122; i++) tick();
        chk("pc_127a", 32'(PC_ADDR), 32'd127);
        PC_LOAD = 1'b1;
        tick();
        chk("pc_prio", 32'(PC_ADDR), 32'h10);
        PC_LOAD = 1'b0;
        for (int i = 0; i < 111; i++) tick();
        chk("pc_127b", 32'(PC_ADDR), 32'd127);
        tick();
        chk("pc_wrap", 32'(PC_ADDR), 32'd0);
        PC_EN = 1'b0;

        // Second IR_EN while busy, then freeze with ack held high
        IR_EN = 1'b1;
        sb.push_back('{opc: 4'h4, ibit: 1'b0, addr: 7'h55});
        tick();
        tick();
        chk("f_busy", 32'(FETCH_BUSY), 32'd1);
        chk("f_maddr", 32'(MEM_ADDR), 32'd0);
        Ena = 1'b1; MEM_ACK = 1'b1; MEM_DATA = 12'h455; PC_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_req", 32'(MEM_REQ), 32'd1);
            chk("f_hold_busy", 32'(FETCH_BUSY), 32'd1);
            chk("f_novalid", 32'(IR_VALID), 32'd0);
            chk("f_hold_opc", 32'(OPCODE), 32'h3);
            chk("f_hold_addr", 32'(InstADDR), 32'h10);
            chk("f_hold_pc", 32'(PC_ADDR), 32'd0);
        end
        Ena = 1'b0; IR_EN = 1'b0; PC_EN = 1'b0;
        tick();
        check_valid("f");
        MEM_ACK = 1'b0;
        tick();
        chk("f_noqueue_busy", 32'(FETCH_BUSY), 32'd0);
        chk("f_noqueue_req", 32'(MEM_REQ), 32'd0);

        // Reset during INDIR, late ack afterwards is dropped
        IR_EN = 1'b1;
        tick();
        IR_EN = 1'b0; MEM_ACK = 1'b1; MEM_DATA = 12'h5A0;
        tick();
        chk("r_indir_maddr", 32'(MEM_ADDR), 32'h20);
        MEM_ACK = 1'b0;
        #2 RST = 1'b0;
        #1;
        check_reset_outputs("r_async");
        MEM_ACK = 1'b1; MEM_DATA = 12'h077;
        tick();
        RST = 1'b1;
        tick();
        tick();
        check_reset_outputs("r_late");
        MEM_ACK = 1'b0;

        chk("valid_pulses", 32'(vcount), 32'd4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
